fifo_wr_arb: RTL and testbench

Round-robin write arbiter that shares one synchronous FIFO write port among `NUM_REQ` requesters. Each requester uses a valid/ready handshake; the arbiter tags every accepted beat with the source ID and writes `{id, data}` into the FIFO. It supports multi-beat bursts, which lock ownership until the `last` beat. An idle-owner watchdog releases stalled bursts. It sits between the input sources (PS/2 decoder, GPIO byte inputs) and the shared `fifo` instance in `top`.

---
 rtl/fifo_wr_arb_pkg.sv | 22 ++
 rtl/fifo_wr_arb_rr_pick.sv | 44 ++++
 rtl/fifo_wr_arb.sv | 163 ++++++++++++++++
 tb/tb_fifo_wr_arb.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arb_pkg
// Description : Shared types and helpers for the round-robin FIFO write
//               arbiter (state encoding, modulo-wrap requester index step).
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_wr_arb_pkg;

    // Arbiter state: IDLE picks round-robin, BURST locks the port to the owner.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Requester index following id, wrapping back to 0 after n-1.
    function automatic int unsigned next_id(input int unsigned id, input int unsigned n);
        return ((id + 32'd1) >= n) ? 32'd0 : (id + 32'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_wr_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Returns the first valid
//               requester scanning ptr, ptr+1, ... modulo NUM_REQ.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    ptr,
    output logic               grant_valid,
    output logic [ID_W-1:0]    grant_id
);

    localparam logic [ID_W:0] c_num_req = (ID_W+1)'(NUM_REQ);

    // Candidate index for scan position k; ptr < NUM_REQ so one subtraction
    // is enough to wrap, which also covers non-power-of-2 requester counts.
    logic [ID_W:0]   w_sum [NUM_REQ];
    logic [ID_W-1:0] w_idx [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_idx
        assign w_sum[k] = {1'b0, ptr} + (ID_W+1)'(k);
        assign w_idx[k] = (w_sum[k] >= c_num_req) ? ID_W'(w_sum[k] - c_num_req)
                                                  : w_sum[k][ID_W-1:0];
    end

    // Scan from farthest to nearest so the nearest valid requester wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (valid[w_idx[k]]) begin
                grant_valid = 1'b1;
                grant_id    = w_idx[k];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arb.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arb
// Description : Round-robin write arbiter sharing one FIFO write port among
//               NUM_REQ valid/ready requesters. Beats are tagged with the
//               source ID; multi-beat bursts lock ownership until last, and
//               an idle-owner watchdog releases stalled bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arb #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ID_W       = $clog2(NUM_REQ),
    parameter int TIMEOUT    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [ID_W+DATA_WIDTH-1:0]    fifo_wr_data,
    output logic                          burst_active,
    output logic [ID_W-1:0]               owner,
    input  logic                          clear_err,
    output logic                          timeout_err
);

    import fifo_wr_arb_pkg::*;

    localparam int              CNT_W          = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(TIMEOUT - 1);

    arb_state_t       r_state,       w_state_nxt;
    logic [ID_W-1:0]  r_ptr,         w_ptr_nxt;
    logic [ID_W-1:0]  r_owner,       w_owner_nxt;
    logic [CNT_W-1:0] r_idle_cnt,    w_idle_cnt_nxt;
    logic             r_timeout_err, w_timeout_err_nxt;

    logic                  w_pick_valid;
    logic [ID_W-1:0]       w_pick_id;
    logic                  w_grant_valid;
    logic [ID_W-1:0]       w_grant_id;
    logic                  w_grant_last;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_grant_data;
    logic [ID_W-1:0]       w_owner_step;
    logic [ID_W-1:0]       w_grant_step;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .valid       (req_valid),
        .ptr         (r_ptr),
        .grant_valid (w_pick_valid),
        .grant_id    (w_pick_id)
    );

    // Grant source: round-robin pick in IDLE, locked owner in BURST.
    always_comb begin
        if (r_state == BURST) begin
            w_grant_valid = req_valid[r_owner];
            w_grant_id    = r_owner;
        end else begin
            w_grant_valid = w_pick_valid;
            w_grant_id    = w_pick_id;
        end
    end

    assign w_grant_last = req_last[w_grant_id];
    // Reset masks the handshake so nothing is written while rst is high.
    assign w_accept     = w_grant_valid & ~fifo_full & ~rst;
    assign w_owner_step = ID_W'(next_id(32'(r_owner), NUM_REQ));
    assign w_grant_step = ID_W'(next_id(32'(w_grant_id), NUM_REQ));

    // Payload mux for the granted requester.
    always_comb begin
        w_grant_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant_id == ID_W'(i)) begin
                w_grant_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign req_ready    = w_accept ? (NUM_REQ'(1) << w_grant_id) : '0;
    assign fifo_wr_en   = w_accept;
    assign fifo_wr_data = {w_grant_id, w_grant_data};
    assign burst_active = (r_state == BURST);
    assign owner        = r_owner;
    assign timeout_err  = r_timeout_err;

    // Next-state, pointer, owner, watchdog and error-flag logic.
    always_comb begin
        w_state_nxt       = r_state;
        w_ptr_nxt         = r_ptr;
        w_owner_nxt       = r_owner;
        w_idle_cnt_nxt    = r_idle_cnt;
        w_timeout_err_nxt = clear_err ? 1'b0 : r_timeout_err;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_grant_last) begin
                        w_ptr_nxt = w_grant_step;
                    end else begin
                        w_state_nxt    = BURST;
                        w_owner_nxt    = w_grant_id;
                        w_idle_cnt_nxt = '0;
                    end
                end
            end
            BURST: begin
                if (w_accept) begin
                    if (w_grant_last) begin
                        w_state_nxt = IDLE;
                        w_ptr_nxt   = w_owner_step;
                        w_owner_nxt = '0;
                    end else begin
                        w_idle_cnt_nxt = '0;
                    end
                end else if (!req_valid[r_owner]) begin
                    // Cycles blocked only by fifo_full fall outside this branch,
                    // so they neither advance nor clear the watchdog.
                    if (r_idle_cnt == c_timeout_last) begin
                        w_state_nxt       = IDLE;
                        w_ptr_nxt         = w_owner_step;
                        w_owner_nxt       = '0;
                        w_idle_cnt_nxt    = '0;
                        w_timeout_err_nxt = 1'b1;
                    end else begin
                        w_idle_cnt_nxt = r_idle_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_ptr         <= '0;
            r_owner       <= '0;
            r_idle_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_ptr         <= w_ptr_nxt;
            r_owner       <= w_owner_nxt;
            r_idle_cnt    <= w_idle_cnt_nxt;
            r_timeout_err <= w_timeout_err_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_arb
// Description : Directed self-checking bench for the round-robin FIFO write
//               arbiter (rotation, bursts, full stalls, watchdog, reset).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arb;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int IDW = 2;
    localparam int TO  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_last  = '1;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              fifo_full = 1'b0;
    logic              fifo_wr_en;
    logic [IDW+DW-1:0] fifo_wr_data;
    logic              burst_active;
    logic [IDW-1:0]    owner;
    logic              clear_err = 1'b0;
    logic              timeout_err;

    logic [DW-1:0] dat [N];
    assign req_data = {dat[3], dat[2], dat[1], dat[0]};

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fifo_wr_arb #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .ID_W       (IDW),
        .TIMEOUT    (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_last     (req_last),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .burst_active (burst_active),
        .owner        (owner),
        .clear_err    (clear_err),
        .timeout_err  (timeout_err)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '1; req_last = '1;
        @(negedge clk);
        n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b expected %b", req_ready, 4'b0000); end
        n_cmp++; if (fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b expected %b", fifo_wr_en, 1'b0); end
        next_cycle();
        rst = 1'b0; req_valid = '0;
        @(negedge clk);
        n_cmp++; if (burst_active !== 1'b0) begin n_fail++; $display("FAIL reset_burst: got %b expected %b", burst_active, 1'b0); end
        n_cmp++; if (owner !== 2'd0) begin n_fail++; $display("FAIL reset_owner: got %0d expected %0d", owner, 0); end
        n_cmp++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected %b", timeout_err, 1'b0); end
        n_cmp++; if (dut.r_ptr !== 2'd0) begin n_fail++; $display("FAIL reset_ptr: got %0d expected %0d", dut.r_ptr, 0); end
        next_cycle();
    endtask

    task automatic test_round_robin();
        logic [IDW+DW-1:0] exp_data;
        logic [N-1:0]      exp_ready;
        req_valid = '1; req_last = '1;
        dat[0] = 8'hA0; dat[1] = 8'hA1; dat[2] = 8'hA2; dat[3] = 8'hA3;
        for (int k = 0; k < 8; k++) begin
            exp_data  = {IDW'(k % 4), 8'(8'hA0 + (k % 4))};
            exp_ready = N'(1) << (k % 4);
            @(negedge clk);
            n_cmp++; if (fifo_wr_en !== 1'b1) begin n_fail++; $display("FAIL rr_wr_en[%0d]: got %b expected %b", k, fifo_wr_en, 1'b1); end
            n_cmp++; if (fifo_wr_data !== exp_data) begin n_fail++; $display("FAIL rr_data[%0d]: got %h expected %h", k, fifo_wr_data, exp_data); end
            n_cmp++; if (req_ready !== exp_ready) begin n_fail++; $display("FAIL rr_ready[%0d]: got %b expected %b", k, req_ready, exp_ready); end
            next_cycle();
        end
        req_valid = '0;
        @(negedge clk);
        n_cmp++; if (dut.r_ptr !== 2'd0) begin n_fail++; $display("FAIL rr_ptr: got %0d expected %0d", dut.r_ptr, 0); end
        n_cmp++; if (fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL rr_idle_wr_en: got %b expected %b", fifo_wr_en, 1'b0); end
        next_cycle();
    endtask

    task automatic test_burst();
        // Single beat from requester 1 moves ptr to 2.
        req_valid = 4'b0010; req_last = '1; dat[1] = 8'h11;
        @(negedge clk);
        n_cmp++; if (fifo_wr_data !== {2'd1, 8'h11}) begin n_fail++; $display("FAIL pre_burst_data: got %h expected %h", fifo_wr_data, {2'd1, 8'h11}); end
        next_cycle();
        req_valid = 4'b1111; req_last = 4'b1011;
        dat[0] = 8'h10; dat[2] = 8'hB0; dat[3] = 8'h33;
        @(negedge clk);
        n_cmp++; if (fifo_wr_data !== {2'd2, 8'hB0}) begin n_fail++; $display("FAIL burst_b1_data: got %h expected %h", fifo_wr_data, {2'd2, 8'hB0}); end
        n_cmp++; if (burst_active !== 1'b0) begin n_fail++; $display("FAIL burst_b1_active: got %b expected %b", burst_active, 1'b0); end
        next_cycle();
        dat[2] = 8'hB1;
        @(negedge clk);
        n_cmp++; if (fifo_wr_data !== {2'd2, 8'hB1}) begin n_fail++; $display("FAIL burst_b2_data: got %h expected %h", fifo_wr_data, {2'd2, 8'hB1}); end
        n_cmp++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL burst_b2_ready: got %b expected %b", req_ready, 4'b0100); end
        n_cmp++; if (burst_active !== 1'b1) begin n_fail++; $display("FAIL burst_b2_active: got %b expected %b", burst_active, 1'b1); end
        n_cmp++; if (owner !== 2'd2) begin n_fail++; $display("FAIL burst_b2_owner: got %0d expected %0d", owner, 2); end
        next_cycle();
        dat[2] = 8'hB2; req_last[2] = 1'b1;
        @(negedge clk);
        n_cmp++; if (fifo_wr_data !== {2'd2, 8'hB2}) begin n_fail++; $display("FAIL burst_b3_data: got %h expected %h", fifo_wr_data, {2'd2, 8'hB2}); end
        n_cmp++; if (burst_active !== 1'b1) begin n_fail++; $display("FAIL burst_b3_active: got %b expected %b", burst_active, 1'b1); end
        next_cycle();
        req_valid[2] = 1'b0;
        @(negedge clk);
        n_cmp++; if (fifo_wr_data !== {2'd3, 8'h33}) begin n_fail++; $display("FAIL burst_next_data: got %h expected %h", fifo_wr_data, {2'd3, 8'h33}); end
        n_cmp++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL burst_next_ready: got %b expected %b", req_ready, 4'b1000); end
        n_cmp++; if (burst_active !== 1'b0) begin n_fail++; $display("FAIL burst_next_active: got %b expected %b", burst_active, 1'b0); end
        next_cycle();
        req_valid = '0;
    endtask

    task automatic test_full_stall();
        fifo_full = 1'b1; req_valid = 4'b0010; req_last = '1; dat[1] = 8'hC1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++; if (fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL stall_wr_en[%0d]: got %b expected %b", i, fifo_wr_en, 1'b0); end
            n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL stall_ready[%0d]: got %b expected %b", i, req_ready, 4'b0000); end
            n_cmp++; if (dut.r_ptr !== 2'd0) begin n_fail++; $display("FAIL stall_ptr[%0d]: got %0d expected %0d", i, dut.r_ptr, 0); end
            next_cycle();
        end
        fifo_full = 1'b0;
        @(negedge clk);
        n_cmp++; if (fifo_wr_en !== 1'b1) begin n_fail++; $display("FAIL unstall_wr_en: got %b expected %b", fifo_wr_en, 1'b1); end
        n_cmp++; if (fifo_wr_data !== {2'd1, 8'hC1}) begin n_fail++; $display("FAIL unstall_data: got %h expected %h", fifo_wr_data, {2'd1, 8'hC1}); end
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        n_cmp++; if (dut.r_ptr !== 2'd2) begin n_fail++; $display("FAIL unstall_ptr: got %0d expected %0d", dut.r_ptr, 2); end
        next_cycle();
    endtask

    task automatic test_timeout();
        req_valid = 4'b0001; req_last = 4'b1110; dat[0] = 8'hD0;
        @(negedge clk);
        n_cmp++; if (fifo_wr_data !== {2'd0, 8'hD0}) begin n_fail++; $display("FAIL to_start_data: got %h expected %h", fifo_wr_data, {2'd0, 8'hD0}); end
        next_cycle();
        req_valid = '0;
        for (int i = 1; i <= TO; i++) begin
            @(negedge clk);
            n_cmp++; if (burst_active !== 1'b1) begin n_fail++; $display("FAIL to_hold[%0d]: got %b expected %b", i, burst_active, 1'b1); end
            next_cycle();
        end
        @(negedge clk);
        n_cmp++; if (burst_active !== 1'b0) begin n_fail++; $display("FAIL to_release: got %b expected %b", burst_active, 1'b0); end
        n_cmp++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_err: got %b expected %b", timeout_err, 1'b1); end
        n_cmp++; if (dut.r_ptr !== 2'd1) begin n_fail++; $display("FAIL to_ptr: got %0d expected %0d", dut.r_ptr, 1); end
        n_cmp++; if (owner !== 2'd0) begin n_fail++; $display("FAIL to_owner: got %0d expected %0d", owner, 0); end
        next_cycle();
        clear_err = 1'b1;
        next_cycle();
        clear_err = 1'b0;
        @(negedge clk);
        n_cmp++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_clear: got %b expected %b", timeout_err, 1'b0); end
        next_cycle();
    endtask

    task automatic test_timeout_clear_collision();
        req_valid = 4'b0001; req_last = 4'b1110; dat[0] = 8'hD1;
        @(negedge clk);
        n_cmp++; if (fifo_wr_data !== {2'd0, 8'hD1}) begin n_fail++; $display("FAIL col_start_data: got %h expected %h", fifo_wr_data, {2'd0, 8'hD1}); end
        next_cycle();
        req_valid = '0;
        for (int i = 1; i < TO; i++) next_cycle();
        clear_err = 1'b1;
        next_cycle();
        clear_err = 1'b0;
        @(negedge clk);
        n_cmp++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL col_err: got %b expected %b", timeout_err, 1'b1); end
        n_cmp++; if (burst_active !== 1'b0) begin n_fail++; $display("FAIL col_release: got %b expected %b", burst_active, 1'b0); end
        next_cycle();
        clear_err = 1'b1;
        next_cycle();
        clear_err = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        req_valid = 4'b1000; req_last = 4'b0111; dat[3] = 8'hE0;
        @(negedge clk);
        n_cmp++; if (fifo_wr_data !== {2'd3, 8'hE0}) begin n_fail++; $display("FAIL rmb_b1_data: got %h expected %h", fifo_wr_data, {2'd3, 8'hE0}); end
        next_cycle();
        dat[3] = 8'hE1;
        @(negedge clk);
        n_cmp++; if (fifo_wr_data !== {2'd3, 8'hE1}) begin n_fail++; $display("FAIL rmb_b2_data: got %h expected %h", fifo_wr_data, {2'd3, 8'hE1}); end
        n_cmp++; if (owner !== 2'd3) begin n_fail++; $display("FAIL rmb_owner: got %0d expected %0d", owner, 3); end
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL rmb_wr_en: got %b expected %b", fifo_wr_en, 1'b0); end
        n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rmb_ready: got %b expected %b", req_ready, 4'b0000); end
        next_cycle();
        rst = 1'b0; req_valid = '0;
        @(negedge clk);
        n_cmp++; if (burst_active !== 1'b0) begin n_fail++; $display("FAIL rmb_burst: got %b expected %b", burst_active, 1'b0); end
        n_cmp++; if (owner !== 2'd0) begin n_fail++; $display("FAIL rmb_owner_clr: got %0d expected %0d", owner, 0); end
        n_cmp++; if (dut.r_ptr !== 2'd0) begin n_fail++; $display("FAIL rmb_ptr: got %0d expected %0d", dut.r_ptr, 0); end
        n_cmp++; if (fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL rmb_post_wr_en: got %b expected %b", fifo_wr_en, 1'b0); end
        next_cycle();
    endtask

    initial begin
        dat[0] = '0; dat[1] = '0; dat[2] = '0; dat[3] = '0;
        test_reset();
        test_round_robin();
        test_burst();
        test_full_stall();
        test_timeout();
        test_timeout_clear_collision();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
